mpu6050_init_sequencer: RTL and testbench



---
 rtl/mpu6050_init_sequencer_if.sv | 33 +++
 rtl/mpu6050_init_sequencer.sv | 192 +++++++++++++++++++
 tb/tb_mpu6050_init_sequencer.sv | 302 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mpu6050_init_sequencer_if.sv
// Signal bundle between the MPU6050 init sequencer and its environment
// (start logic, power-on delay block, I2C master, attitude-solver status).
interface mpu6050_init_sequencer_if;
  logic       start;
  logic       pwr_delay_req;
  logic       pwr_delay_done;
  logic       wr_req;
  logic [7:0] wr_reg;
  logic [7:0] wr_data;
  logic       wr_ack;
  logic       rd_req;
  logic       rd_ack;
  logic       i2c_err;
  logic       sample_tick;
  logic       init_done;
  logic       init_err;
  logic [2:0] state_o;

  // Handshake: wr_req/rd_req are levels held (payload stable) until wr_ack/rd_ack,
  // i2c_err or timeout; ack/err are single-cycle pulses, only honoured while the
  // matching request is high. A request always drops for >=1 cycle between attempts.
  modport master (
    input  start, pwr_delay_done, wr_ack, rd_ack, i2c_err,
    output pwr_delay_req, wr_req, wr_reg, wr_data, rd_req,
    output sample_tick, init_done, init_err, state_o
  );

  modport slave (
    output start, pwr_delay_done, wr_ack, rd_ack, i2c_err,
    input  pwr_delay_req, wr_req, wr_reg, wr_data, rd_req,
    input  sample_tick, init_done, init_err, state_o
  );
endinterface

// File: rtl/mpu6050_init_sequencer.sv
// Brings the MPU6050 out of power-on: waits for the power delay, writes the
// configuration table over I2C with retries, then launches periodic burst reads.
module mpu6050_init_sequencer #(
  parameter int unsigned SAMPLE_PERIOD = 100000,
  parameter int unsigned ACK_TIMEOUT   = 1000000,
  parameter int unsigned MAX_RETRY     = 3,
  parameter int unsigned TIMER_W       = 32
) (
  input logic                       clk,
  input logic                       rst,
  mpu6050_init_sequencer_if.master  bus
);

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_PWR_WAIT  = 3'd1,
    ST_CFG_ISSUE = 3'd2,
    ST_CFG_WAIT  = 3'd3,
    ST_RUN       = 3'd4,
    ST_RD_WAIT   = 3'd5,
    ST_ERROR     = 3'd6
  } state_t;

  localparam int RETRY_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
  localparam logic [RETRY_W-1:0] RETRY_LIMIT = RETRY_W'(MAX_RETRY);
  localparam logic [TIMER_W-1:0] ACK_LAST    = TIMER_W'(ACK_TIMEOUT - 1);
  localparam logic [TIMER_W-1:0] PERIOD_LAST = TIMER_W'(SAMPLE_PERIOD - 1);
  localparam logic [2:0]         LAST_IDX    = 3'd4;

  state_t               state;
  logic [TIMER_W-1:0]   timer;
  logic [RETRY_W-1:0]   retry;
  logic [2:0]           idx;
  logic                 pwr_req_q;
  logic                 wr_req_q;
  logic                 rd_req_q;
  logic                 tick_q;
  logic                 done_q;
  logic                 err_q;
  logic [7:0]           wr_reg_q;
  logic [7:0]           wr_data_q;
  logic                 ack_timeout;
  logic                 can_retry;

  // {register address, data} for each configuration write, issued in index order.
  function automatic logic [15:0] cfg_entry(input logic [2:0] i);
    case (i)
      3'd0:    return 16'h6B00;
      3'd1:    return 16'h1907;
      3'd2:    return 16'h1A06;
      3'd3:    return 16'h1B18;
      3'd4:    return 16'h1C01;
      default: return 16'h0000;
    endcase
  endfunction

  function automatic logic [TIMER_W-1:0] timer_inc(input logic [TIMER_W-1:0] t);
    return (&t) ? t : t + TIMER_W'(1);
  endfunction

  assign ack_timeout = (timer == ACK_LAST);
  assign can_retry   = (retry < RETRY_LIMIT);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      timer     <= '0;
      retry     <= '0;
      idx       <= '0;
      pwr_req_q <= 1'b0;
      wr_req_q  <= 1'b0;
      rd_req_q  <= 1'b0;
      tick_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      wr_reg_q  <= '0;
      wr_data_q <= '0;
    end else begin
      tick_q <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (bus.start) begin
            state     <= ST_PWR_WAIT;
            pwr_req_q <= 1'b1;
            idx       <= '0;
            retry     <= '0;
          end
        end

        ST_PWR_WAIT: begin
          if (bus.pwr_delay_done) begin
            state     <= ST_CFG_ISSUE;
            pwr_req_q <= 1'b0;
          end
        end

        ST_CFG_ISSUE: begin
          {wr_reg_q, wr_data_q} <= cfg_entry(idx);
          wr_req_q <= 1'b1;
          timer    <= '0;
          state    <= ST_CFG_WAIT;
        end

        ST_CFG_WAIT: begin
          if (bus.wr_ack) begin
            // Ack beats a coincident i2c_err: the write did land.
            wr_req_q <= 1'b0;
            retry    <= '0;
            if (idx == LAST_IDX) begin
              state  <= ST_RUN;
              timer  <= '0;
              done_q <= 1'b1;
            end else begin
              idx   <= idx + 3'd1;
              state <= ST_CFG_ISSUE;
            end
          end else if (bus.i2c_err || ack_timeout) begin
            wr_req_q <= 1'b0;
            if (can_retry) begin
              retry <= retry + RETRY_W'(1);
              state <= ST_CFG_ISSUE;
            end else begin
              state <= ST_ERROR;
              err_q <= 1'b1;
            end
          end else begin
            timer <= timer_inc(timer);
          end
        end

        ST_RUN: begin
          if (timer == PERIOD_LAST) begin
            rd_req_q <= 1'b1;
            timer    <= '0;
            state    <= ST_RD_WAIT;
          end else begin
            timer <= timer_inc(timer);
          end
        end

        ST_RD_WAIT: begin
          if (!rd_req_q) begin
            // Gap cycle after a failed attempt: relaunch the same read.
            rd_req_q <= 1'b1;
            timer    <= '0;
          end else if (bus.rd_ack) begin
            tick_q   <= 1'b1;
            rd_req_q <= 1'b0;
            retry    <= '0;
            timer    <= TIMER_W'(1);
            state    <= ST_RUN;
          end else if (bus.i2c_err || ack_timeout) begin
            rd_req_q <= 1'b0;
            timer    <= '0;
            if (can_retry) begin
              retry <= retry + RETRY_W'(1);
            end else begin
              state  <= ST_ERROR;
              done_q <= 1'b0;
              err_q  <= 1'b1;
            end
          end else begin
            timer <= timer_inc(timer);
          end
        end

        ST_ERROR: begin
          pwr_req_q <= 1'b0;
          wr_req_q  <= 1'b0;
          rd_req_q  <= 1'b0;
          done_q    <= 1'b0;
          err_q     <= 1'b1;
        end

        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.pwr_delay_req = pwr_req_q;
  assign bus.wr_req        = wr_req_q;
  assign bus.wr_reg        = wr_reg_q;
  assign bus.wr_data       = wr_data_q;
  assign bus.rd_req        = rd_req_q;
  assign bus.sample_tick   = tick_q;
  assign bus.init_done     = done_q;
  assign bus.init_err      = err_q;
  assign bus.state_o       = state;

endmodule

// File: tb/tb_mpu6050_init_sequencer.sv
// Directed bench for mpu6050_init_sequencer: scenario table for the config
// sequence plus hand-written sequences for RUN timing, errors and mid-flight reset.
module tb_mpu6050_init_sequencer;

  localparam int SP     = 20;
  localparam int TO     = 16;
  localparam int MR     = 3;
  localparam int WR_LAT = 5;
  localparam int RD_LAT = 3;

  typedef struct {
    int         err_idx;
    int         both_idx;
    bit         no_ack;
    bit         exp_done;
    bit         exp_err;
    logic [2:0] exp_state;
  } scen_t;

  logic clk = 1'b0;
  logic rst;

  mpu6050_init_sequencer_if bus();

  mpu6050_init_sequencer #(
    .SAMPLE_PERIOD (SP),
    .ACK_TIMEOUT   (TO),
    .MAX_RETRY     (MR),
    .TIMER_W       (32)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // ---------------- clock / watchdog ----------------
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard state ----------------
  int n_checks = 0;
  int n_pass   = 0;
  logic [15:0] exp_q[$];
  logic [15:0] cfg_tab [5];
  scen_t       scen [4];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
  endtask

  // Responder/monitor mode, written by the test sequence.
  bit         no_ack   = 1'b0;
  bit         err_en   = 1'b0;
  bit         err_used = 1'b0;
  bit         both_en  = 1'b0;
  bit         stray_wr = 1'b0;
  logic [7:0] err_reg  = '0;
  logic [7:0] both_reg = '0;

  int cyc = 0, wr_age = 0, rd_age = 0, wr_action = 0;
  int wr_rises = 0, rd_rises = 0, last_rd_cyc = 0, done_cyc = 0;
  bit wr_prev = 0, rd_prev = 0, done_prev = 0, rd_ack_gave = 0;
  bit first_rd_pending = 0, wr_unstable = 0;
  logic [15:0] wr_cur = '0;

  // I2C responder + monitor. Behaves as a registered responder: its ack flop is
  // set LAT edges after the edge that first samples the request, so the pulse
  // is seen by the DUT in the (LAT+1)th cycle after the request's first cycle.
  always @(negedge clk) begin
    cyc++;
    bus.wr_ack  = 1'b0;
    bus.rd_ack  = 1'b0;
    bus.i2c_err = 1'b0;
    if (rst) begin
      wr_age = 0; rd_age = 0; wr_prev = 0; rd_prev = 0; done_prev = 0;
      rd_ack_gave = 0; wr_rises = 0; rd_rises = 0; first_rd_pending = 0;
    end else begin
      if (rd_ack_gave || bus.sample_tick) check("sample_tick", bus.sample_tick, rd_ack_gave);
      rd_ack_gave = 0;
      if (bus.init_done && !done_prev) begin
        done_cyc = cyc;
        first_rd_pending = 1;
      end
      done_prev = bus.init_done;

      if (bus.wr_req && !wr_prev) begin
        wr_rises++;
        wr_cur = {bus.wr_reg, bus.wr_data};
        wr_unstable = 0;
        if (exp_q.size() == 0) begin
          n_checks++;
          $display("FAIL wr_unexpected: got write 0x%h, want no write", wr_cur);
        end else begin
          check("wr_seq", wr_cur, exp_q.pop_front());
        end
        if (no_ack) wr_action = 3;
        else if (err_en && !err_used && bus.wr_reg == err_reg) begin
          wr_action = 1;
          err_used = 1;
        end else if (both_en && bus.wr_reg == both_reg) wr_action = 2;
        else wr_action = 0;
      end
      if (bus.wr_req) begin
        wr_age++;
        if ({bus.wr_reg, bus.wr_data} != wr_cur) wr_unstable = 1;
        if (wr_age == WR_LAT + 2) begin
          case (wr_action)
            0: bus.wr_ack = 1'b1;
            1: bus.i2c_err = 1'b1;
            2: begin bus.wr_ack = 1'b1; bus.i2c_err = 1'b1; end
            default: ;
          endcase
        end
      end else begin
        if (wr_prev) begin
          check("wr_stable", 32'(wr_unstable), 0);
          if (no_ack) check("wr_pulse_len", wr_age, TO);
        end
        wr_age = 0;
        if (stray_wr) begin
          bus.wr_ack = 1'b1;
          stray_wr = 0;
        end
      end
      wr_prev = bus.wr_req;

      if (bus.rd_req && !rd_prev) begin
        rd_rises++;
        if (first_rd_pending) begin
          check("first_rd_delay", cyc - done_cyc, SP);
          first_rd_pending = 0;
        end else begin
          check("rd_period", cyc - last_rd_cyc, SP + 1 + RD_LAT);
        end
        last_rd_cyc = cyc;
      end
      if (bus.rd_req) begin
        rd_age++;
        if (rd_age == RD_LAT + 2) begin
          bus.rd_ack = 1'b1;
          rd_ack_gave = 1;
        end
      end else begin
        rd_age = 0;
      end
      rd_prev = bus.rd_req;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.start = 1'b0;
    bus.pwr_delay_done = 1'b0;
    stray_wr = 1'b0;
    tick(3);
    rst = 1'b0;
    tick(1);
  endtask

  task automatic pulse_start();
    bus.start = 1'b1;
    tick(1);
    bus.start = 1'b0;
  endtask

  task automatic power_up();
    pulse_start();
    check("pwr_wait_state", bus.state_o, 3'd1);
    tick(9);
    check("pwr_req_held", bus.pwr_delay_req, 1);
    bus.pwr_delay_done = 1'b1;
    tick(1);
    check("pwr_req_drop", bus.pwr_delay_req, 0);
    check("cfg_issue_state", bus.state_o, 3'd2);
    bus.pwr_delay_done = 1'b0;
  endtask

  task automatic wait_status(input int budget);
    for (int i = 0; i < budget && !(bus.init_done || bus.init_err); i++) tick(1);
    check("status_seen", 32'(bus.init_done | bus.init_err), 1);
  endtask

  function automatic logic [31:0] all_outputs();
    return {bus.pwr_delay_req, bus.wr_req, bus.rd_req, bus.sample_tick, bus.init_done,
            bus.init_err, bus.state_o, bus.wr_reg, bus.wr_data};
  endfunction

  // ---------------- test sequence ----------------
  initial begin
    cfg_tab[0] = 16'h6B00;
    cfg_tab[1] = 16'h1907;
    cfg_tab[2] = 16'h1A06;
    cfg_tab[3] = 16'h1B18;
    cfg_tab[4] = 16'h1C01;
    //            err  both no_ack done err state
    scen[0] = '{-1, -1, 1'b0, 1'b1, 1'b0, 3'd4};
    scen[1] = '{ 2, -1, 1'b0, 1'b1, 1'b0, 3'd4};
    scen[2] = '{-1, -1, 1'b1, 1'b0, 1'b1, 3'd6};
    scen[3] = '{-1,  4, 1'b0, 1'b1, 1'b0, 3'd4};

    rst = 1'b1;
    bus.start = 1'b0;
    bus.pwr_delay_done = 1'b0;
    tick(3);
    check("reset_outputs", all_outputs(), 0);
    rst = 1'b0;
    tick(2);
    check("idle_hold", all_outputs(), 0);

    for (int s = 0; s < 4; s++) begin
      do_reset();
      no_ack   = scen[s].no_ack;
      err_en   = (scen[s].err_idx >= 0);
      err_used = 1'b0;
      err_reg  = err_en ? cfg_tab[scen[s].err_idx][15:8] : 8'h00;
      both_en  = (scen[s].both_idx >= 0);
      both_reg = both_en ? cfg_tab[scen[s].both_idx][15:8] : 8'h00;
      exp_q.delete();
      if (scen[s].no_ack) begin
        for (int k = 0; k <= MR; k++) exp_q.push_back(cfg_tab[0]);
      end else begin
        for (int k = 0; k < 5; k++) begin
          exp_q.push_back(cfg_tab[k]);
          if (k == scen[s].err_idx) exp_q.push_back(cfg_tab[k]);
        end
      end

      power_up();
      wait_status(400);
      check("status_done", bus.init_done, scen[s].exp_done);
      check("status_err", bus.init_err, scen[s].exp_err);
      check("status_state", bus.state_o, scen[s].exp_state);
      check("writes_left", exp_q.size(), 0);
      check("wr_req_idle", bus.wr_req, 0);
      if (scen[s].both_idx >= 0) check("retry_cleared", 32'(dut.retry), 0);

      if (scen[s].exp_err) begin
        pulse_start();
        tick(5);
        check("err_sticky_state", bus.state_o, 3'd6);
        check("err_sticky_reqs", {bus.pwr_delay_req, bus.wr_req, bus.rd_req}, 0);
        check("err_sticky_flag", {bus.init_err, bus.init_done}, 2'b10);
      end

      if (s == 0) begin
        // RUN: reads at +20, +44, +68 from init_done; stray ack lands between them.
        tick(30);
        stray_wr = 1'b1;
        tick(50);
        check("rd_count", rd_rises, 3);
        check("run_done", {bus.init_done, bus.init_err}, 2'b10);
        check("run_state", 32'(bus.state_o == 3'd4 || bus.state_o == 3'd5), 1);
      end
    end

    // Reset in the middle of the index-3 write, then restart with the delay
    // already expired (single-cycle PWR_WAIT).
    do_reset();
    no_ack = 1'b0; err_en = 1'b0; both_en = 1'b0;
    exp_q.delete();
    for (int k = 0; k < 4; k++) exp_q.push_back(cfg_tab[k]);
    power_up();
    for (int i = 0; i < 200 && wr_rises < 4; i++) tick(1);
    check("wr_rises_idx3", wr_rises, 4);
    tick(2);
    check("cfg_wait_idx3", bus.state_o, 3'd3);
    rst = 1'b1;
    tick(1);
    check("mid_reset_outputs", all_outputs(), 0);
    rst = 1'b0;
    check("mid_reset_writes_left", exp_q.size(), 0);
    tick(1);
    for (int k = 0; k < 5; k++) exp_q.push_back(cfg_tab[k]);
    bus.pwr_delay_done = 1'b1;
    pulse_start();
    check("restart_pwr_wait", bus.state_o, 3'd1);
    tick(1);
    check("restart_min_dwell", {bus.state_o, bus.pwr_delay_req}, {3'd2, 1'b0});
    bus.pwr_delay_done = 1'b0;
    tick(1);
    check("restart_idx0", {bus.state_o, bus.wr_req, bus.wr_reg, bus.wr_data}, {3'd3, 1'b1, 16'h6B00});
    wait_status(400);
    check("restart_done", {bus.init_done, bus.init_err}, 2'b10);
    check("restart_writes_left", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
